cdb_wb_arbiter: RTL and testbench

//  Completion-bus scheduler behind the functional-unit cluster. Accepts result packets from NUM_FU units
//  (4 ALU, MUL, BRU, AGU order), buffers each in a per-FU FIFO, and grants up to NUM_CDB results per cycle

---
 rtl/cdb_wb_arbiter_pkg.sv | 32 +++
 rtl/cdb_wb_arbiter_wb_fifo.sv | 51 +++++
 rtl/cdb_wb_arbiter.sv | 135 +++++++++++++
 tb/tb_cdb_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_wb_arbiter_pkg.sv
// Shared types and constants for the completion-bus (CDB) writeback arbiter.
package cdb_wb_arbiter_pkg;
  localparam int NUM_CDB_DEF = 4;
  localparam int XLEN_DEF    = 32;
  localparam int PRF_W_DEF   = 6;
  localparam int ROB_W_DEF   = 5;
  localparam int SRC_W       = 3;

  typedef enum logic [SRC_W-1:0] {
    FU_ALU_0 = 3'd0,
    FU_ALU_1 = 3'd1,
    FU_ALU_2 = 3'd2,
    FU_ALU_3 = 3'd3,
    FU_MUL   = 3'd4,
    FU_BRU   = 3'd5,
    FU_LSQ   = 3'd6
  } fu_id_e;

  localparam int NUM_FU_DEF = int'(FU_LSQ) + 1;

  typedef struct packed {
    logic [XLEN_DEF-1:0]  result;
    logic [PRF_W_DEF-1:0] dest_prn;
    logic [ROB_W_DEF-1:0] rob_entry;
    logic [SRC_W-1:0]     src;
  } CDB_PACKET;

  // Circular FU index step; idx is always < 2*n at every call site.
  function automatic int wrap_idx(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction
endpackage

// File: rtl/cdb_wb_arbiter_wb_fifo.sv
// Per-FU result FIFO: DEPTH entries, synchronous flush, registered occupancy count.
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 43,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];
endmodule

// File: rtl/cdb_wb_arbiter.sv
// Completion-bus scheduler: per-FU FIFOs, round-robin grant of up to NUM_CDB results per cycle.
// Optional build macro CDB_BYPASS_EN lets an empty FU's incoming packet compete in the same-cycle scan.
module cdb_wb_arbiter
  import cdb_wb_arbiter_pkg::*;
#(
  parameter int NUM_FU    = NUM_FU_DEF,
  parameter int NUM_CDB   = NUM_CDB_DEF,
  parameter int BUF_DEPTH = 2,
  parameter int XLEN      = XLEN_DEF,
  parameter int PRF_WIDTH = PRF_W_DEF,
  parameter int ROB_WIDTH = ROB_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pipe_flush,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  logic [NUM_FU*XLEN-1:0]        fu_result,
  input  logic [NUM_FU*PRF_WIDTH-1:0]   fu_dest_prn,
  input  logic [NUM_FU*ROB_WIDTH-1:0]   fu_rob_entry,
  output logic [NUM_FU-1:0]             fu_ready,
  output logic [NUM_CDB-1:0]            cdb_valid,
  output logic [NUM_CDB*XLEN-1:0]       cdb_result,
  output logic [NUM_CDB*PRF_WIDTH-1:0]  cdb_dest_prn,
  output logic [NUM_CDB*ROB_WIDTH-1:0]  cdb_rob_entry,
  output logic [NUM_CDB*3-1:0]          cdb_src
);
  localparam int EW    = XLEN + PRF_WIDTH + ROB_WIDTH;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int FW    = $clog2(NUM_FU);
  localparam int PW    = (NUM_CDB > 1) ? $clog2(NUM_CDB) : 1;

  logic [CNT_W-1:0]  count     [NUM_FU];
  logic [EW-1:0]     fifo_head [NUM_FU];
  logic [EW-1:0]     head_pkt  [NUM_FU];
  logic [EW-1:0]     in_pkt    [NUM_FU];
  logic [NUM_FU-1:0] head_vld;
  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] bypass_take;

  logic [FW-1:0]      rr_ptr;
  logic [FW-1:0]      rr_next;
  logic [FW-1:0]      idx;
  logic [PW-1:0]      slot;
  logic               slots_full;
  logic [NUM_CDB-1:0] port_vld;
  logic [EW-1:0]      port_pkt [NUM_CDB];
  logic [SRC_W-1:0]   port_src [NUM_CDB];

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    assign in_pkt[i]   = {fu_result[i*XLEN +: XLEN], fu_dest_prn[i*PRF_WIDTH +: PRF_WIDTH],
                          fu_rob_entry[i*ROB_WIDTH +: ROB_WIDTH]};
    // Ready comes from the registered count only, never from this cycle's grant.
    assign fu_ready[i] = (count[i] < CNT_W'(BUF_DEPTH));
`ifdef CDB_BYPASS_EN
    assign head_vld[i]    = (count[i] != '0) || fu_valid[i];
    assign head_pkt[i]    = (count[i] == '0) ? in_pkt[i] : fifo_head[i];
    assign bypass_take[i] = grant[i] && (count[i] == '0);
`else
    assign head_vld[i]    = (count[i] != '0);
    assign head_pkt[i]    = fifo_head[i];
    assign bypass_take[i] = 1'b0;
`endif
    assign push[i] = fu_valid[i] && fu_ready[i] && !bypass_take[i] && !pipe_flush;
    assign pop[i]  = grant[i] && !bypass_take[i] && !pipe_flush;

    wb_fifo #(.DEPTH(BUF_DEPTH), .W(EW), .CNT_W(CNT_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (pipe_flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (in_pkt[i]),
      .dout  (fifo_head[i]),
      .count (count[i])
    );
  end

  // Circular scan from rr_ptr; the k-th valid head found goes to port k.
  always_comb begin
    grant      = '0;
    port_vld   = '0;
    rr_next    = rr_ptr;
    idx        = '0;
    slot       = '0;
    slots_full = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      port_pkt[k] = '0;
      port_src[k] = '0;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      idx = FW'(wrap_idx(int'(rr_ptr) + k, NUM_FU));
      if (head_vld[idx] && !slots_full) begin
        grant[idx]     = 1'b1;
        port_vld[slot] = 1'b1;
        port_pkt[slot] = head_pkt[idx];
        port_src[slot] = SRC_W'(idx);
        rr_next        = FW'(wrap_idx(int'(idx) + 1, NUM_FU));
        if (slot == PW'(NUM_CDB - 1)) slots_full = 1'b1;
        else                          slot = slot + PW'(1);
      end
    end
  end

  // Output stage: granted packets register onto the CDB ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr        <= '0;
      cdb_valid     <= '0;
      cdb_result    <= '0;
      cdb_dest_prn  <= '0;
      cdb_rob_entry <= '0;
      cdb_src       <= '0;
    end else if (pipe_flush) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
    end else begin
      rr_ptr    <= rr_next;
      cdb_valid <= port_vld;
      for (int k = 0; k < NUM_CDB; k++) begin
        cdb_result[k*XLEN +: XLEN]           <= port_pkt[k][EW-1 -: XLEN];
        cdb_dest_prn[k*PRF_WIDTH +: PRF_WIDTH] <= port_pkt[k][ROB_WIDTH +: PRF_WIDTH];
        cdb_rob_entry[k*ROB_WIDTH +: ROB_WIDTH] <= port_pkt[k][0 +: ROB_WIDTH];
        cdb_src[k*3 +: 3]                    <= port_src[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !pipe_flush)
      assert ((fu_valid & ~fu_ready) == '0)
        else $error("cdb_wb_arbiter: fu_valid while fu_ready low, packet dropped");
  end
endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Bench for cdb_wb_arbiter: directed vector table, corner sequences, random traffic vs a queue model.
module tb_cdb_wb_arbiter;
  import cdb_wb_arbiter_pkg::*;

  localparam int NF = 7, NC = 4, DEPTH = 2, XL = 32, PRW = 6, RW = 5;
`ifdef CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 1;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pipe_flush = 1'b0;
  logic [NF-1:0]     fu_valid = '0;
  logic [NF*XL-1:0]  fu_result = '0;
  logic [NF*PRW-1:0] fu_dest_prn = '0;
  logic [NF*RW-1:0]  fu_rob_entry = '0;
  logic [NF-1:0]     fu_ready;
  logic [NC-1:0]     cdb_valid;
  logic [NC*XL-1:0]  cdb_result;
  logic [NC*PRW-1:0] cdb_dest_prn;
  logic [NC*RW-1:0]  cdb_rob_entry;
  logic [NC*3-1:0]   cdb_src;

  always #5 clk = ~clk;

  cdb_wb_arbiter #(.NUM_FU(NF), .NUM_CDB(NC), .BUF_DEPTH(DEPTH), .XLEN(XL),
                   .PRF_WIDTH(PRW), .ROB_WIDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush), .fu_valid(fu_valid),
    .fu_result(fu_result), .fu_dest_prn(fu_dest_prn), .fu_rob_entry(fu_rob_entry),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_result(cdb_result),
    .cdb_dest_prn(cdb_dest_prn), .cdb_rob_entry(cdb_rob_entry), .cdb_src(cdb_src)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one queue per FU, a scan pointer, and the expected registered outputs.
  CDB_PACKET mq [NF][$];
  int        rr_m;
  logic [NC-1:0] exp_vld;
  CDB_PACKET exp_pkt [NC];
  int        seq = 0;

  task automatic model_reset();
    for (int f = 0; f < NF; f++) mq[f].delete();
    rr_m = 0;
    exp_vld = '0;
  endtask

  function automatic CDB_PACKET dut_pkt(input int k);
    CDB_PACKET p;
    p.result    = cdb_result[k*XL +: XL];
    p.dest_prn  = cdb_dest_prn[k*PRW +: PRW];
    p.rob_entry = cdb_rob_entry[k*RW +: RW];
    p.src       = cdb_src[k*3 +: 3];
    return p;
  endfunction

  task automatic check_outputs();
    logic [NF-1:0] rdy;
    for (int f = 0; f < NF; f++) rdy[f] = (mq[f].size() < DEPTH);
    check("fu_ready", 64'(fu_ready), 64'(rdy));
    for (int k = 0; k < NC; k++) begin
      check($sformatf("cdb_valid[%0d]", k), 64'(cdb_valid[k]), 64'(exp_vld[k]));
      if (exp_vld[k] && cdb_valid[k])
        check($sformatf("cdb_pkt[%0d]", k), 64'(dut_pkt(k)), 64'(exp_pkt[k]));
    end
  endtask

  // Called at a negedge: check, drive one cycle of inputs, advance the model, return at next negedge.
  task automatic step(input logic [NF-1:0] want, input logic flush);
    logic [NF-1:0] v;
    logic [NF-1:0] byp;
    CDB_PACKET inc [NF];
    int picks, last, i;
    check_outputs();
    v = '0;
    for (int f = 0; f < NF; f++) begin
      inc[f].result    = $urandom;
      inc[f].dest_prn  = PRW'($urandom_range(0, 63));
      inc[f].rob_entry = RW'(seq);
      inc[f].src       = 3'(f);
      seq++;
      if (want[f] && mq[f].size() < DEPTH) v[f] = 1'b1;
      fu_result[f*XL +: XL]      = inc[f].result;
      fu_dest_prn[f*PRW +: PRW]  = inc[f].dest_prn;
      fu_rob_entry[f*RW +: RW]   = inc[f].rob_entry;
    end
    fu_valid   = v;
    pipe_flush = flush;
    if (flush) begin
      model_reset();
    end else begin
      exp_vld = '0;
      picks = 0;
      last = 0;
      byp = '0;
      for (int k = 0; k < NF; k++) begin
        i = (rr_m + k) % NF;
        if (picks < NC && (mq[i].size() > 0 || (BYP && v[i]))) begin
          if (mq[i].size() > 0) exp_pkt[picks] = mq[i].pop_front();
          else begin
            exp_pkt[picks] = inc[i];
            byp[i] = 1'b1;
          end
          exp_vld[picks] = 1'b1;
          picks++;
          last = i;
        end
      end
      if (picks > 0) rr_m = (last + 1) % NF;
      for (int f = 0; f < NF; f++)
        if (v[f] && !byp[f]) mq[f].push_back(inc[f]);
    end
    @(negedge clk);
    fu_valid   = '0;
    pipe_flush = 1'b0;
  endtask

  typedef struct {
    logic [NF-1:0]       mask;
    logic [NC-1:0]       v1;
    logic [NC-1:0][2:0]  s1;
    logic [NC-1:0]       v2;
    logic [NC-1:0][2:0]  s2;
  } vec_t;

  function automatic logic [NC-1:0][2:0] srcs(input int a, input int b, input int c, input int d);
    logic [NC-1:0][2:0] s;
    s[0] = 3'(a); s[1] = 3'(b); s[2] = 3'(c); s[3] = 3'(d);
    return s;
  endfunction

  task automatic check_ports(input int e, input logic [NC-1:0] v, input logic [NC-1:0][2:0] s);
    logic [31:0] r;
    check($sformatf("tbl%0d cdb_valid", e), 64'(cdb_valid), 64'(v));
    for (int k = 0; k < NC; k++) begin
      if (v[k]) begin
        r = 32'hA000_0000 | (32'(e) << 8) | 32'(s[k]);
        check($sformatf("tbl%0d src[%0d]", e, k), 64'(cdb_src[k*3 +: 3]), 64'(s[k]));
        check($sformatf("tbl%0d result[%0d]", e, k), 64'(cdb_result[k*XL +: XL]), 64'(r));
      end
    end
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{7'h10, 4'b0001, srcs(4, 0, 0, 0), 4'b0000, srcs(0, 0, 0, 0)};
    tbl[1] = '{7'h7F, 4'b1111, srcs(0, 1, 2, 3), 4'b0111, srcs(4, 5, 6, 0)};
    tbl[2] = '{7'h41, 4'b0011, srcs(0, 6, 0, 0), 4'b0000, srcs(0, 0, 0, 0)};
    tbl[3] = '{7'h36, 4'b1111, srcs(1, 2, 4, 5), 4'b0000, srcs(0, 0, 0, 0)};
    tbl[4] = '{7'h7C, 4'b1111, srcs(2, 3, 4, 5), 4'b0001, srcs(6, 0, 0, 0)};
    tbl[5] = '{7'h00, 4'b0000, srcs(0, 0, 0, 0), 4'b0000, srcs(0, 0, 0, 0)};
    tbl[6] = '{7'h6E, 4'b1111, srcs(1, 2, 3, 5), 4'b0001, srcs(6, 0, 0, 0)};

    // Reset state while rst_n held low.
    #3;
    check("reset cdb_valid", 64'(cdb_valid), 64'h0);
    check("reset fu_ready", 64'(fu_ready), 64'h7F);
    check("reset cdb_src", 64'(cdb_src), 64'h0);
    check("reset cdb_result", 64'(cdb_result[63:0]), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors, each from a freshly flushed state (rr_ptr = 0).
    for (int e = 0; e < 7; e++) begin
      pipe_flush = 1'b1;
      @(negedge clk);
      pipe_flush = 1'b0;
      for (int f = 0; f < NF; f++) begin
        fu_result[f*XL +: XL]     = 32'hA000_0000 | (32'(e) << 8) | 32'(f);
        fu_dest_prn[f*PRW +: PRW] = PRW'(f + 1);
        fu_rob_entry[f*RW +: RW]  = RW'(f);
      end
      fu_valid = tbl[e].mask;
      @(negedge clk);
      fu_valid = '0;
      if (LAT == 2) @(negedge clk);
      check_ports(e, tbl[e].v1, tbl[e].s1);
      @(negedge clk);
      check_ports(e, tbl[e].v2, tbl[e].s2);
      @(negedge clk);
      @(negedge clk);
    end

    // Hand off to the model from a known flushed state.
    model_reset();
    step('0, 1'b1);

    // Backpressure: all FUs issue every cycle they are allowed to.
    repeat (3) step(7'h7F, 1'b0);
    repeat (4) step('0, 1'b0);

    // Flush with entries buffered and a same-cycle issue that must vanish.
    step(7'h7F, 1'b0);
    step(7'h03, 1'b0);
    step(7'h0C, 1'b1);
    repeat (3) step('0, 1'b0);
    step(7'h7F, 1'b0);
    repeat (3) step('0, 1'b0);

    // Wrap: drive rr_ptr to 5, then heads at FU5, FU6, FU0.
    step(7'h1F, 1'b0);
    repeat (3) step('0, 1'b0);
    step(7'h61, 1'b0);
    if (LAT == 2) step('0, 1'b0);
    check("wrap cdb_valid", 64'(cdb_valid), 64'h7);
    check("wrap cdb_src", 64'(cdb_src[8:0]), 64'({3'd0, 3'd6, 3'd5}));
    repeat (3) step('0, 1'b0);

    // Random traffic with occasional flushes and one asynchronous reset mid-run.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        #2 rst_n = 1'b0;
        #1;
        check("async reset cdb_valid", 64'(cdb_valid), 64'h0);
        check("async reset fu_ready", 64'(fu_ready), 64'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
      end
      step(NF'($urandom), ($urandom_range(0, 39) == 0));
    end
    repeat (4) step('0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
